// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types for circular-queue FIFO clients
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/fifo.sv
// rtl/fifo.sv - circular-queue FIFO with show-ahead read port
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_w_data,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_r_data,
    output logic                  o_empty,
    output logic                  o_full
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q;
    logic [ADDR_WIDTH:0]   rd_ptr_q;
    logic                  do_wr;
    logic                  do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty  = (wr_ptr_q == rd_ptr_q);
    assign o_full   = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                      (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign do_wr    = i_wr & ~o_full;
    assign do_rd    = i_rd & ~o_empty;
    assign o_r_data = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_wr) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= i_w_data;
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - pops N words from a FIFO onto a registered valid/ready stream
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic                  i_abort,
    input  logic                  i_empty,
    input  logic [DATA_WIDTH-1:0] i_r_data,
    output logic                  o_rd,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [LEN_WIDTH-1:0]  o_count
);
    state_t                state_q,     state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0]  count_q,     count_d;
    logic [DATA_WIDTH-1:0] data_q,      data_d;
    logic                  valid_q,     valid_d;
    logic                  done_q,      done_d;
    logic                  handshake;
    logic                  reg_free;
    logic                  pop;

    assign handshake = valid_q & i_ready;
    assign reg_free  = ~valid_q | i_ready;
    assign pop       = (state_q == READ) && (remaining_q != '0) && !i_empty
                       && reg_free && !i_abort;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        data_d      = data_q;
        valid_d     = valid_q;
        done_d      = 1'b0;

        if (handshake) count_d = count_q + LEN_WIDTH'(1);

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    count_d = '0;
                    if (i_len != '0) begin
                        state_d     = READ;
                        remaining_d = i_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                // Abort drops any held word; it has already left the FIFO.
                if (i_abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else if (pop) begin
                    data_d      = i_r_data;
                    valid_d     = 1'b1;
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) state_d = FLUSH;
                end else if (handshake) begin
                    valid_d = 1'b0;
                end
            end
            FLUSH: begin
                if (i_abort || handshake) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            count_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    assign o_rd    = pop;
    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_busy  = (state_q != IDLE);
    assign o_done  = done_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - self-checking bench for fifo_burst_reader behind a fifo
module tb_fifo_burst_reader;
    localparam int DW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, ready, f_wr;
    logic [LW-1:0] len;
    logic [DW-1:0] f_wdata, f_rdata, data;
    logic          f_empty, f_full, rd, valid, busy, done;
    logic [LW-1:0] count;

    always #5 clk = ~clk;

    fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(4)) u_fifo (
        .i_clk(clk), .i_reset_n(rst_n), .i_wr(f_wr), .i_w_data(f_wdata),
        .i_rd(rd), .o_r_data(f_rdata), .o_empty(f_empty), .o_full(f_full)
    );

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_len(len),
        .i_abort(abort), .i_empty(f_empty), .i_r_data(f_rdata), .o_rd(rd),
        .o_valid(valid), .o_data(data), .i_ready(ready), .o_busy(busy),
        .o_done(done), .o_count(count)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    int            rd_cnt = 0;
    int            hs_cnt = 0;
    logic [DW-1:0] mq[$];
    logic [DW-1:0] pend[$];
    logic [DW-1:0] got[$];
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reference: words leave the FIFO model in write order, and the stream must
    // deliver popped words in that same order, one pop per popped word.
    always @(negedge clk) begin
        logic [DW-1:0] w;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (rd) begin
                rd_cnt++;
                n_cmp++;
                if (f_empty !== 1'b0 || (valid && !ready)) begin
                    n_err++;
                    $display("FAIL pop_guard: empty=%b occupied=%b, required empty=0 occupied=0",
                             f_empty, valid && !ready);
                end
                if (mq.size() > 0) begin
                    w = mq.pop_front();
                    pend.push_back(w);
                end
            end
            if (valid && ready) begin
                hs_cnt++;
                got.push_back(data);
                n_cmp++;
                if (pend.size() == 0 || data !== pend[0]) begin
                    n_err++;
                    $display("FAIL stream_order: got %h, required %h", data,
                             pend.size() > 0 ? pend[0] : 8'hxx);
                end
                if (pend.size() > 0) w = pend.pop_front();
            end
            if (prev_hold && valid) begin
                n_cmp++;
                if (data !== prev_data) begin
                    n_err++;
                    $display("FAIL data_hold: got %h, required %h", data, prev_data);
                end
            end
            prev_hold = valid && !ready;
            prev_data = data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        rd_cnt = 0;
        hs_cnt = 0;
        got.delete();
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        f_wr = 1'b1;
        f_wdata = d;
        mq.push_back(d);
        cyc();
        f_wr = 1'b0;
    endtask

    task automatic start_burst(input int l);
        start = 1'b1;
        len = LW'(l);
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input int mode, input int budget, output bit seen, output bit busy_at);
        seen = 1'b0;
        busy_at = 1'b1;
        for (int i = 0; i < budget && !seen; i++) begin
            ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[i % 4] : 1'($urandom % 2);
            cyc();
            if (done) begin
                seen = 1'b1;
                busy_at = busy;
            end
        end
        ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; abort = 0; ready = 0; f_wr = 0; len = '0; f_wdata = '0;
        #1;
        n_cmp++;
        if ({rd, valid, busy, done, count, data} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, required all zero", {rd, valid, busy, done, count, data});
        end
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_full_rate();
        logic [DW-1:0] exp_d[3] = '{8'h11, 8'h22, 8'h33};
        clear_stats();
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        ready = 1'b1;
        start_burst(3);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (valid !== (k >= 2 && k <= 4) || done !== (k == 5)) begin
                n_err++;
                $display("FAIL full_rate_timing c%0d: valid=%b done=%b, required valid=%b done=%b",
                         k, valid, done, k >= 2 && k <= 4, k == 5);
            end
            if (k >= 2 && k <= 4) begin
                n_cmp++;
                if (data !== exp_d[k-2]) begin
                    n_err++;
                    $display("FAIL full_rate_data c%0d: got %h, required %h", k, data, exp_d[k-2]);
                end
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (count !== 4'd3 || f_empty !== 1'b1 || rd_cnt != 3) begin
            n_err++;
            $display("FAIL full_rate_end: count=%0d empty=%b pops=%0d, required 3 1 3", count, f_empty, rd_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] ex[4];
        bit seen, b;
        clear_stats();
        for (int i = 0; i < 4; i++) begin
            ex[i] = DW'($urandom);
            push_word(ex[i]);
        end
        start_burst(4);
        wait_done(1, 60, seen, b);
        n_cmp++;
        if (!seen || b || count !== 4'd4 || got.size() != 4) begin
            n_err++;
            $display("FAIL backpressure_end: done=%b busy=%b count=%0d words=%0d, required 1 0 4 4",
                     seen, b, count, got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== ex[i]) begin
                n_err++;
                $display("FAIL backpressure_word%0d: got %h, required %h", i, got[i], ex[i]);
            end
        end
    endtask

    task automatic test_underflow();
        bit seen, b;
        clear_stats();
        ready = 1'b1;
        start_burst(2);
        repeat (4) cyc();
        n_cmp++;
        if (rd_cnt != 0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL underflow_stall: pops=%0d busy=%b, required 0 1", rd_cnt, busy);
        end
        push_word(8'hA5);
        repeat (4) cyc();
        push_word(8'h5A);
        wait_done(0, 40, seen, b);
        n_cmp++;
        if (!seen || got.size() != 2 || got[0] !== 8'hA5 || got[1] !== 8'h5A || count !== 4'd2) begin
            n_err++;
            $display("FAIL underflow_delivery: done=%b words=%0d count=%0d, required 1 2 2 (A5,5A)",
                     seen, got.size(), count);
        end
    endtask

    task automatic test_abort();
        logic [DW-1:0] ex[5];
        bit seen, b;
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            ex[i] = DW'($urandom);
            push_word(ex[i]);
        end
        ready = 1'b1;
        start_burst(5);
        for (int i = 0; i < 20 && hs_cnt < 2; i++) cyc();
        ready = 1'b0;
        abort = 1'b1;
        n_cmp++;
        if (valid !== 1'b1 || hs_cnt != 2) begin
            n_err++;
            $display("FAIL abort_setup: valid=%b handshakes=%0d, required 1 2", valid, hs_cnt);
        end
        cyc();
        abort = 1'b0;
        pend.delete();
        n_cmp++;
        if (valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || count !== 4'd2 || rd_cnt != 3) begin
            n_err++;
            $display("FAIL abort_end: valid=%b done=%b busy=%b count=%0d pops=%0d, required 0 1 0 2 3",
                     valid, done, busy, count, rd_cnt);
        end
        clear_stats();
        start_burst(2);
        wait_done(0, 20, seen, b);
        n_cmp++;
        if (!seen || got.size() != 2 || got[0] !== ex[3] || got[1] !== ex[4]) begin
            n_err++;
            $display("FAIL abort_fifo_loss: done=%b words=%0d, required 1 2 (%h,%h)", seen, got.size(), ex[3], ex[4]);
        end
    endtask

    task automatic test_zero_len();
        clear_stats();
        start_burst(0);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || count !== 4'd0) begin
            n_err++;
            $display("FAIL zero_len_done: done=%b busy=%b count=%0d, required 1 0 0", done, busy, count);
        end
        cyc();
        n_cmp++;
        if (done !== 1'b0 || rd_cnt != 0) begin
            n_err++;
            $display("FAIL zero_len_after: done=%b pops=%0d, required 0 0", done, rd_cnt);
        end
    endtask

    task automatic test_ignored_start();
        bit seen, b;
        clear_stats();
        for (int i = 0; i < 3; i++) push_word(DW'($urandom));
        ready = 1'b1;
        start_burst(3);
        cyc();
        start = 1'b1;
        len = 4'd1;
        cyc();
        start = 1'b0;
        wait_done(0, 20, seen, b);
        n_cmp++;
        if (!seen || got.size() != 3 || count !== 4'd3 || rd_cnt != 3 || f_empty !== 1'b1) begin
            n_err++;
            $display("FAIL ignored_start: done=%b words=%0d count=%0d pops=%0d empty=%b, required 1 3 3 3 1",
                     seen, got.size(), count, rd_cnt, f_empty);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [DW-1:0] ex[2];
        bit seen, b;
        clear_stats();
        for (int i = 0; i < 4; i++) push_word(DW'($urandom));
        ready = 1'b0;
        start_burst(4);
        repeat (3) cyc();
        n_cmp++;
        if (valid !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_setup: valid=%b busy=%b, required 1 1", valid, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rd, valid, busy, done, count, data} !== '0) begin
            n_err++;
            $display("FAIL rst_async: got %b, required all zero", {rd, valid, busy, done, count, data});
        end
        mq.delete();
        pend.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc();
        clear_stats();
        for (int i = 0; i < 2; i++) begin
            ex[i] = DW'($urandom);
            push_word(ex[i]);
        end
        start_burst(2);
        wait_done(0, 20, seen, b);
        n_cmp++;
        if (!seen || got.size() != 2 || got[0] !== ex[0] || got[1] !== ex[1] || count !== 4'd2) begin
            n_err++;
            $display("FAIL rst_recover: done=%b words=%0d count=%0d, required 1 2 2", seen, got.size(), count);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] ex[$];
        bit seen, b;
        int l, need, extra;
        for (int it = 0; it < 8; it++) begin
            clear_stats();
            ex.delete();
            l = int'($urandom_range(1, 8));
            need = (mq.size() >= l) ? 0 : l - mq.size();
            extra = (mq.size() + need + 3 <= 16) ? int'($urandom_range(0, 3)) : 0;
            for (int i = 0; i < need + extra; i++) push_word(DW'($urandom));
            for (int i = 0; i < l; i++) ex.push_back(mq[i]);
            start_burst(l);
            wait_done(2, 300, seen, b);
            n_cmp++;
            if (!seen || b || int'(count) != l || rd_cnt != l || got.size() != l) begin
                n_err++;
                $display("FAIL random_end it%0d: done=%b busy=%b count=%0d pops=%0d words=%0d, required 1 0 %0d",
                         it, seen, b, count, rd_cnt, got.size(), l);
            end
            for (int i = 0; i < l && i < got.size(); i++) begin
                n_cmp++;
                if (got[i] !== ex[i]) begin
                    n_err++;
                    $display("FAIL random_word it%0d/%0d: got %h, required %h", it, i, got[i], ex[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_backpressure();
        test_underflow();
        test_abort();
        test_zero_len();
        test_ignored_start();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side client for the circular-queue `fifo`: on a start request it pops exactly N words from the FIFO's read port. It presents the words on a registered valid/ready stream toward downstream consumers such as a UART TX or packet builder. It owns `i_rd` pacing, so a FIFO is never popped when empty and no word is lost under downstream backpressure. Sustained throughput is one word per clock.

## Interface
- `DATA_WIDTH`, 8, word width; must match the attached `fifo`.
- `LEN_WIDTH`, 4, width of burst length and count; max burst is 2^LEN_WIDTH-1.

- `i_clk`  in  1  single system clock; all logic on the rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  burst request; sampled only in IDLE.
- `i_len`  in  LEN_WIDTH  words to transfer; captured with `i_start`.
- `i_abort`  in  1  terminates the burst early.
- `i_empty`  in  1  FIFO `o_empty`.
- `i_r_data`  in  DATA_WIDTH  FIFO head word; valid whenever `i_empty`=0.
- `o_rd`  out  1  pop strobe to FIFO `i_rd`; combinational.
- `o_valid`  out  1  stream word valid.
- `o_data`  out  DATA_WIDTH  stream word; registered.
- `i_ready`  in  1  downstream accepts when `o_valid & i_ready`.
- `o_busy`  out  1  high in READ and FLUSH.
- `o_done`  out  1  one-cycle pulse at burst end.
- `o_count`  out  LEN_WIDTH  words accepted downstream in the current or last burst.

## Operation
- **Reset values:** state IDLE; `o_valid`, `o_data`, `o_busy`, `o_done` and `o_count` are 0. `o_rd` is 0 because it is combinational from IDLE.
- **Output register:** a single register. It is free when `o_valid`=0 or when a handshake occurs this cycle.
- **Pop rule:**
  - `o_rd = (state==READ) & (remaining!=0) & ~i_empty & reg_free & ~i_abort`.
  - On `o_rd`, `o_data <= i_r_data`, `o_valid <= 1`, and `remaining` decrements.
  - `o_rd` is never asserted when `i_empty`=1.
- **No handshake, no pop:** `o_valid` clears on a handshake without a pop.
- **`o_count`:** increments on every handshake; clears on accepted `i_start`.
- **IDLE**
  - `i_start` with `i_len`≠0 → READ; `remaining` ← `i_len`, `o_count` ← 0.
  - `i_start` with `i_len`=0 → stay in IDLE, pulse `o_done` next cycle, `o_count` ← 0.
- **READ**
  - When `remaining` reaches 0 (on the final pop) → FLUSH.
  - `i_abort` → IDLE. `o_valid` clears, an unaccepted held word is dropped (already popped), and `o_done` pulses.
- **FLUSH**
  - Waits for the handshake of the last word → IDLE with `o_done` pulse.
  - `i_abort` here behaves as in READ.
- **Ignored inputs:** `i_start` while busy is ignored. `i_abort` in IDLE is ignored.
- **Stall behavior:** an empty FIFO mid-burst stalls READ indefinitely (no timeout). `o_valid` drops once the held word is accepted.
- **Data stability:** `o_data` is stable while `o_valid & ~i_ready`.
- **Arithmetic:** `remaining` and `o_count` are LEN_WIDTH bits and never wrap, since `o_count` ≤ `i_len`.

## Timing
- **Cycle 0:** `i_start` sampled.
- **Cycle 1:** state READ; first `o_rd` if the FIFO is non-empty.
- **Cycle 2:** `o_valid`=1 with the first word.
- **Steady state:** with `i_ready`=1 and a non-empty FIFO, one `o_rd` and one handshake per cycle.
- **End of burst:** `o_done` is high in the cycle after the final handshake or abort. `o_busy` falls in that same cycle.
- **Empty-burst latency:** `i_len`=0 gives `o_done` at cycle 1.
- **Reset mid-burst:** asynchronous return to reset values. Popped but unaccepted words are lost; FIFO pointers are the FIFO's own concern.
- **Back-to-back bursts:** a new `i_start` is accepted in the `o_done` cycle (state is already IDLE).

## Structure
- **Package:** `fifo_pkg` holds the `state_t` enum {IDLE, READ, FLUSH}. It is shared with future FIFO clients.
- **Sub-modules:** none required. The pop/output-register logic stays inline.
- **Bench:** instantiates `fifo` upstream with `fifo.i_rd` ← `o_rd`, `i_empty` ← `fifo.o_empty`, and `i_r_data` ← `fifo.o_r_data`.

## Test plan
- **Full-rate burst:** preload FIFO with 0x11,0x22,0x33; `i_start`, `i_len`=3, `i_ready`=1 → `o_valid` cycles 2–4 carrying 0x11,0x22,0x33. `o_done` at cycle 5, `o_count`=3, FIFO empty, and `o_rd` asserted exactly 3 times.
- **Backpressure:** 4 words; `i_ready` toggles 1,0,0,1,… → `o_data` holds during stalls, order is preserved, no pop while the register is occupied, `o_count`=4.
- **Underflow:** FIFO empty, `i_len`=2 → `o_rd` stays 0 and `o_busy`=1. Write 0xA5 then, 5 cycles later, 0x5A → both delivered in order, then `o_done`.
- **Abort:** `i_len`=5, abort after 2 handshakes with a word held → `o_valid` clears next cycle, `o_done` pulses, `o_count`=2, and the FIFO has lost exactly 3 words.
- **Zero length and ignored start:** `i_len`=0 → `o_done` at cycle 1 with no `o_rd`. `i_start` during a busy burst → no effect on `remaining`.
- **Reset mid-burst:** assert `i_reset_n`=0 asynchronously in READ → all outputs 0 immediately; after release, state is IDLE and a new burst works.
